// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
//
// WIDTH-bit, eight-operation bitwise logic unit followed by a STAGES-deep
// valid/ready register pipeline, plus a saturating counter of delivered
// results.
//
// The operation is evaluated combinationally from a/b/op and captured into the
// first stage. Later stages forward data unchanged. Every stage is ready when
// it is empty or when the stage after it is ready. Empty stages therefore
// fill even while the consumer stalls, and a fully stalled pipe holds exactly
// STAGES entries.
//
// Ports:
//   clk        in   1        rising-edge clock
//   reset      in   1        asynchronous, active-low reset
//   in_valid   in   1        a/b/op valid this cycle
//   in_ready   out  1        pipeline accepts an input this cycle
//                            (combinational from out_ready through the chain)
//   a, b       in   WIDTH    operands
//   op         in   3        0 AND, 1 OR, 2 XOR, 3 NOT a, 4 NAND, 5 NOR,
//                            6 XNOR, 7 PASS a
//   out_valid  out  1        result is valid
//   out_ready  in   1        consumer takes the result this cycle
//   result     out  WIDTH    registered result (last stage data)
//   out_count  out  COUNT_W  delivered results, saturating at all-ones
//   clr_count  in   1        synchronous clear of out_count; wins over a
//                            simultaneous increment
// -----------------------------------------------------------------------------
module logic_unit_pipe #(
   parameter int WIDTH   = 8,
   parameter int STAGES  = 2,
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [2:0]         op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic [COUNT_W-1:0] out_count,
   input  logic               clr_count
);

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_NOT  = 3'd3;
   localparam logic [2:0] OP_NAND = 3'd4;
   localparam logic [2:0] OP_NOR  = 3'd5;
   localparam logic [2:0] OP_XNOR = 3'd6;
   localparam logic [2:0] OP_PASS = 3'd7;

   // -------------------------------------------------------------------------
   // Operation evaluation (input side, combinational)
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0] op_value;

   always_comb begin
      op_value = a;
      case (op)
         OP_AND:  op_value = a & b;
         OP_OR:   op_value = a | b;
         OP_XOR:  op_value = a ^ b;
         OP_NOT:  op_value = ~a;
         OP_NAND: op_value = ~(a & b);
         OP_NOR:  op_value = ~(a | b);
         OP_XNOR: op_value = ~(a ^ b);
         OP_PASS: op_value = a;
         default: op_value = a;
      endcase
   end

   // -------------------------------------------------------------------------
   // Pipeline stages
   // stage_ready[STAGES] is the consumer; stage_ready[0] is in_ready.
   // -------------------------------------------------------------------------
   logic [STAGES:0]              stage_ready;
   logic [STAGES-1:0]            stage_valid;
   logic [STAGES-1:0][WIDTH-1:0] stage_data;

   // The ready chain is evaluated in one process, walking from the consumer
   // back to the input, so no signal depends combinationally on itself.
   always_comb begin
      logic ready_next;
      ready_next          = out_ready;
      stage_ready         = '0;
      stage_ready[STAGES] = out_ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
         ready_next     = !stage_valid[i] || ready_next;
         stage_ready[i] = ready_next;
      end
   end

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         logic             valid_reg;
         logic [WIDTH-1:0] data_reg;
         logic             src_valid;
         logic [WIDTH-1:0] src_data;

         if (gi == 0) begin : g_first
            assign src_valid = in_valid;
            assign src_data  = op_value;
         end else begin : g_follow
            assign src_valid = stage_valid[gi-1];
            assign src_data  = stage_data[gi-1];
         end

         // A ready stage always takes the upstream valid bit. Data is only
         // captured alongside a valid bit, so don't-care operands presented
         // with in_valid=0 never reach the registers.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               valid_reg <= 1'b0;
               data_reg  <= '0;
            end else if (stage_ready[gi]) begin
               valid_reg <= src_valid;
               if (src_valid) begin
                  data_reg <= src_data;
               end
            end
         end

         assign stage_valid[gi] = valid_reg;
         assign stage_data[gi]  = data_reg;
      end
   endgenerate

   assign in_ready  = stage_ready[0];
   assign out_valid = stage_valid[STAGES-1];
   assign result    = stage_data[STAGES-1];

   // -------------------------------------------------------------------------
   // Delivered-result counter
   // -------------------------------------------------------------------------
   logic               out_xfer;
   logic [COUNT_W-1:0] count_reg;
   logic [COUNT_W-1:0] count_next;

   assign out_xfer = out_valid && out_ready;

   always_comb begin
      count_next = count_reg;
      if (clr_count) begin
         count_next = '0;
      end else if (out_xfer && (count_reg != {COUNT_W{1'b1}})) begin
         count_next = count_reg + COUNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign out_count = count_reg;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_pipe
//
// Four instances run in lockstep from shared stimulus:
//   u_dut0  WIDTH=8 STAGES=2 COUNT_W=16
//   u_dut1  WIDTH=8 STAGES=1 COUNT_W=16
//   u_dut2  WIDTH=8 STAGES=4 COUNT_W=16
//   u_dut3  WIDTH=8 STAGES=2 COUNT_W=4
// Each instance has its own reference: occupancy flags per slot, an ordered
// buffer of expected results computed from the operation table, and an
// integer delivered-count.
// -----------------------------------------------------------------------------
module tb_logic_unit_pipe;

   localparam int NDUT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        out_ready;
   logic        clr_count;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [2:0]  op;

   logic [NDUT-1:0] in_ready;
   logic [NDUT-1:0] out_valid;
   logic [7:0]      result [NDUT];
   logic [15:0]     cnt0, cnt1, cnt2;
   logic [3:0]      cnt3;

   always #5 clk = ~clk;

   logic_unit_pipe #(.WIDTH(8), .STAGES(2), .COUNT_W(16)) u_dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
      .a(a), .b(b), .op(op), .out_valid(out_valid[0]), .out_ready(out_ready),
      .result(result[0]), .out_count(cnt0), .clr_count(clr_count));

   logic_unit_pipe #(.WIDTH(8), .STAGES(1), .COUNT_W(16)) u_dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
      .a(a), .b(b), .op(op), .out_valid(out_valid[1]), .out_ready(out_ready),
      .result(result[1]), .out_count(cnt1), .clr_count(clr_count));

   logic_unit_pipe #(.WIDTH(8), .STAGES(4), .COUNT_W(16)) u_dut2 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[2]),
      .a(a), .b(b), .op(op), .out_valid(out_valid[2]), .out_ready(out_ready),
      .result(result[2]), .out_count(cnt2), .clr_count(clr_count));

   logic_unit_pipe #(.WIDTH(8), .STAGES(2), .COUNT_W(4)) u_dut3 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[3]),
      .a(a), .b(b), .op(op), .out_valid(out_valid[3]), .out_ready(out_ready),
      .result(result[3]), .out_count(cnt3), .clr_count(clr_count));

   // ---------------------------------------------------------------- checking
   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   function automatic int stg_of(input int d);
      case (d)
         0:       return 2;
         1:       return 1;
         2:       return 4;
         default: return 2;
      endcase
   endfunction

   function automatic int cw_of(input int d);
      return (d == 3) ? 4 : 16;
   endfunction

   function automatic longint get_cnt(input int d);
      case (d)
         0:       return longint'(cnt0);
         1:       return longint'(cnt1);
         2:       return longint'(cnt2);
         default: return longint'(cnt3);
      endcase
   endfunction

   function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] y,
                                         input logic [2:0] o);
      case (o)
         3'd0:    return x & y;
         3'd1:    return x | y;
         3'd2:    return x ^ y;
         3'd3:    return ~x;
         3'd4:    return ~(x & y);
         3'd5:    return ~(x | y);
         3'd6:    return ~(x ^ y);
         default: return x;
      endcase
   endfunction

   // ----------------------------------------------------------------- model
   bit          mvld [NDUT][1:5];
   bit          mrdy [NDUT][1:5];
   logic [7:0]  mbuf [NDUT][0:63];
   int          mhead [NDUT];
   int          mtail [NDUT];
   longint      mcnt [NDUT];

   // observation bookkeeping
   int          cyc = 0;
   int          first_acc [NDUT];
   int          first_out [NDUT];
   int          last_out [NDUT];
   int          acc_cnt [NDUT];
   bit          last_acc [NDUT];
   longint      samp_cnt [NDUT];
   logic [7:0]  log0 [0:63];
   int          log0_n;

   task automatic model_reset();
      for (int d = 0; d < NDUT; d++) begin
         for (int k = 1; k <= 5; k++) mvld[d][k] = 1'b0;
         mhead[d] = 0;
         mtail[d] = 0;
         mcnt[d]  = 0;
      end
   endtask

   task automatic track_reset();
      for (int d = 0; d < NDUT; d++) begin
         first_acc[d] = -1;
         first_out[d] = -1;
         last_out[d]  = -1;
         acc_cnt[d]   = 0;
      end
      log0_n = 0;
   endtask

   task automatic check_reset_state(input string tag);
      for (int d = 0; d < NDUT; d++) begin
         chk($sformatf("%s out_valid[%0d]", tag, d), out_valid[d], 0);
         chk($sformatf("%s result[%0d]", tag, d), result[d], 0);
         chk($sformatf("%s out_count[%0d]", tag, d), get_cnt(d), 0);
         chk($sformatf("%s in_ready[%0d]", tag, d), in_ready[d], 1);
      end
   endtask

   // One clock cycle: drive on the falling edge, compare 1 ns later, then
   // advance every model across the rising edge.
   task automatic step(input logic iv, input logic ordy, input logic clr,
                       input logic [7:0] av, input logic [7:0] bv,
                       input logic [2:0] opv);
      bit acc [NDUT];
      bit xo  [NDUT];
      @(negedge clk);
      in_valid = iv; out_ready = ordy; clr_count = clr; a = av; b = bv; op = opv;
      cyc++;
      #1;
      for (int d = 0; d < NDUT; d++) begin
         int s = stg_of(d);
         mrdy[d][s+1] = ordy;
         for (int k = s; k >= 1; k--) mrdy[d][k] = !mvld[d][k] || mrdy[d][k+1];
         chk($sformatf("in_ready[%0d]", d), in_ready[d], mrdy[d][1]);
         chk($sformatf("out_valid[%0d]", d), out_valid[d], mvld[d][s]);
         if (mvld[d][s])
            chk($sformatf("result[%0d]", d), result[d], mbuf[d][mhead[d] % 64]);
         samp_cnt[d] = get_cnt(d);
         chk($sformatf("out_count[%0d]", d), samp_cnt[d], mcnt[d]);
         acc[d] = iv && mrdy[d][1];
         xo[d]  = mvld[d][s] && ordy;
         last_acc[d] = acc[d];
      end
      @(posedge clk);
      for (int d = 0; d < NDUT; d++) begin
         int s = stg_of(d);
         for (int k = s; k >= 1; k--)
            if (mrdy[d][k]) mvld[d][k] = (k == 1) ? iv : mvld[d][k-1];
         if (xo[d]) begin
            if (first_out[d] < 0) first_out[d] = cyc;
            last_out[d] = cyc;
            if (d == 0) begin
               $display("dut0 cycle %0d: delivered result=%02h", cyc, mbuf[0][mhead[0] % 64]);
               log0[log0_n % 64] = result[0];
               log0_n++;
            end
            mhead[d]++;
         end
         if (acc[d]) begin
            if (first_acc[d] < 0) first_acc[d] = cyc;
            acc_cnt[d]++;
            mbuf[d][mtail[d] % 64] = ref_op(av, bv, opv);
            mtail[d]++;
         end
         if (clr) mcnt[d] = 0;
         else if (xo[d] && mcnt[d] < ((64'd1 << cw_of(d)) - 1)) mcnt[d]++;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0);
   endtask

   // ---------------------------------------------------------------- stimulus
   logic [7:0] tp1_exp [8] = '{8'hC0, 8'hFC, 8'h3C, 8'h0F, 8'h3F, 8'h03, 8'hC3, 8'hF0};
   int         idx;

   initial begin
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_count = 1'b0;
      a = '0; b = '0; op = '0;
      model_reset();
      track_reset();
      repeat (2) @(negedge clk);
      #1;
      check_reset_state("por");
      @(negedge clk);
      reset = 1'b1;

      // 1: operation table stream, F0 op CC
      track_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 8'hF0, 8'hCC, 3'(i));
      idle(6);
      chk("tp1 n", log0_n, 8);
      for (int i = 0; i < 8; i++) chk($sformatf("tp1 res%0d", i), log0[i], tp1_exp[i]);
      for (int d = 0; d < NDUT; d++) begin
         chk($sformatf("tp1 latency[%0d]", d), first_out[d] - first_acc[d], stg_of(d));
         chk($sformatf("tp1 b2b[%0d]", d), last_out[d] - first_out[d], 7);
         chk($sformatf("tp1 count[%0d]", d), samp_cnt[d], 8);
      end

      // 2: full stall capacity, then drain
      track_reset();
      for (int i = 0; i < 6; i++)
         step(1'b1, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 3'($urandom));
      for (int d = 0; d < NDUT; d++)
         chk($sformatf("stall cap[%0d]", d), acc_cnt[d], stg_of(d));
      idle(8);
      chk("stall drained", log0_n, 2);

      // 3: alternating out_ready, PASS of 00..0F
      track_reset();
      idx = 0;
      for (int i = 0; i < 60; i++) begin
         step(idx < 16, (i % 2) == 0, 1'b0, 8'(idx), 8'h55, 3'd7);
         if (last_acc[0]) idx++;
      end
      idle(6);
      chk("alt n", log0_n, 16);
      for (int i = 0; i < 16; i++) chk($sformatf("alt res%0d", i), log0[i], i);

      // 4: saturation of the 4-bit counter, clear priority
      step(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 3'd0);
      for (int i = 0; i < 20; i++)
         step(1'b1, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 3'($urandom));
      idle(6);
      chk("sat cnt3", samp_cnt[3], 15);
      chk("cnt20 cnt0", samp_cnt[0], 20);
      step(1'b1, 1'b1, 1'b0, 8'h11, 8'h22, 3'd1);
      step(1'b1, 1'b1, 1'b0, 8'h33, 8'h44, 3'd1);
      step(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 3'd0);
      chk("clr xfer dut3", out_valid[3], 1);
      step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0);
      chk("clr prio cnt0", samp_cnt[0], 0);
      chk("clr prio cnt3", samp_cnt[3], 0);
      idle(6);

      // 5: asynchronous reset with a full, stalled pipe
      for (int i = 0; i < 5; i++)
         step(1'b1, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 3'($urandom));
      @(negedge clk);
      in_valid = 1'b0; clr_count = 1'b0;
      #2;
      chk("pre-reset out_valid dut2", out_valid[2], 1);
      reset = 1'b0;
      #1;
      check_reset_state("midreset");
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      track_reset();
      step(1'b1, 1'b1, 1'b0, 8'h5A, 8'h0F, 3'd2);
      idle(5);
      chk("post-reset value", log0[0], 8'h55);
      chk("post-reset latency", first_out[0] - first_acc[0], 2);

      // random traffic
      for (int i = 0; i < 400; i++)
         step(1'($urandom), ($urandom % 10) < 7, ($urandom % 40) == 0,
              8'($urandom), 8'($urandom), 3'($urandom));
      idle(8);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised successor to the single-bit not/and gates: a WIDTH-bit, 8-operation bitwise logic unit behind a STAGES-deep valid/ready pipeline. Includes a saturating completed-transaction counter. Sits between a producer issuing operand pairs and a consumer that may stall. Serves as the registered, flow-controlled building block for datapath logic.

Parameters:
WIDTH, 8, operand/result bit width (>=1)
STAGES, 2, number of pipeline register stages (1..4); unstalled latency in cycles
COUNT_W, 16, width of the transaction counter

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  operand pair and op are valid this cycle
in_ready  output  1  pipeline can accept an input this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  operation select, sampled with a/b on acceptance
out_valid  output  1  result is valid
out_ready  input  1  consumer accepts the result this cycle
result  output  WIDTH  registered result
out_count  output  COUNT_W  number of results delivered, saturating
clr_count  input  1  synchronous clear of out_count

Behaviour:
- Reset (reset=0, asynchronous): all stage valid bits 0, all stage data 0, out_count 0. Outputs: out_valid=0, result=0, out_count=0, in_ready=1 (combinational, follows empty pipe). Reset release is synchronous to clk; first acceptance is possible on the first rising edge with reset=1.
- Op encoding (bitwise over WIDTH):
  - 0 AND: a&b
  - 1 OR: a|b
  - 2 XOR: a^b
  - 3 NOT: ~a, b ignored
  - 4 NAND: ~(a&b)
  - 5 NOR: ~(a|b)
  - 6 XNOR: ~(a^b)
  - 7 PASS: a
- Op computation: combinational on the input side. The computed value is captured into stage 1; later stages forward data unchanged.
- Handshake:
  - Input transfer when in_valid&&in_ready.
  - Output transfer when out_valid&&out_ready.
  - Stage k holds valid_k and data_k; ready_k = !valid_k || ready_(k+1); ready_(STAGES+1) = out_ready.
  - in_ready = ready_1 (combinational from out_ready through the chain; no skid buffer).
  - On each edge, stage k with ready_k loads valid_(k-1)/data_(k-1). Stage 1 loads in_valid/computed op.
  - A stage that is not ready holds its contents.
- Outputs: out_valid = valid_STAGES; result = data_STAGES.
- Stall hold rule: while out_valid=1 and out_ready=0, result must stay stable and out_valid must stay 1.
- Latency: with out_ready held 1, a result accepted at edge N appears at out_valid after edge N+STAGES-1. Latency is STAGES cycles from acceptance to availability.
- Throughput: 1 result per cycle, no bubbles inserted.
- Stall capacity: a full stall accepts exactly STAGES inputs before in_ready falls to 0. On release, data drains in order with no loss or duplication.
- Bubbles: empty stages are filled even while downstream stalls, because ready_k is true when valid_k=0.
- out_count:
  - Increments by 1 on each output transfer.
  - Saturates at 2^COUNT_W-1 (no wrap).
  - clr_count=1 sets it to 0 on the next edge and takes priority over a simultaneous increment.
- Reset mid-operation: all in-flight data is discarded immediately, out_valid drops asynchronously, and out_count is cleared.
- Illegal/X inputs: a, b and op are don't-care when in_valid=0. No state changes from them.

Test Plan:
1. Reset then stream (WIDTH=8, STAGES=2), out_ready=1, a=8'hF0, b=8'hCC, ops 0..7 on consecutive cycles -> results C0,FC,3C,0F,3F,03,C3,F0 on out_valid starting 2 cycles after the first acceptance, back-to-back; out_count=8.
2. Backpressure: out_ready=0 while in_valid=1 with 4 distinct inputs -> exactly 2 accepted, in_ready=0 thereafter, result stable; raise out_ready -> remaining inputs delivered in order, none lost or duplicated.
3. Alternating out_ready (1,0,1,0...) with a continuous input stream of a=00..0F, op=7 -> outputs exactly 00..0F in order; in_ready matches the ready-chain equation every cycle.
4. Counter saturation with COUNT_W=4: deliver 20 results -> out_count stops at 15. Assert clr_count in the same cycle as a transfer -> out_count=0.
5. Reset mid-flight: pipe full and stalled, drive reset=0 between clock edges -> out_valid=0, result=0 and out_count=0 immediately (before the next edge). After release, first new input emerges after 2 cycles with the correct value.
6. STAGES=1 and STAGES=4 builds, with the scenario 1 stimulus -> same result sequence, latency of 1 and 4 cycles respectively; a full stall holds exactly 1 and 4 entries.
